// File: rtl/pcie_rx_req_dispatch.sv
// pcie_rx_req_dispatch
//  Single-entry RX TLP header dispatcher. A header accepted from the RX header
//  extractor is registered, classified from its {fmt,type}, and then either
//  handed to the read, write or completion engine, queued as an
//  Unsupported-Request completion job, or dropped (unsupported posted TLPs).
//
//  Ports
//   clk, rst                      application clock, synchronous active-high reset
//   rx_hdr_valid / rx_hdr_ready   header handshake; ready only while idle
//   rx_fmt, rx_type, rx_req_id, rx_tag, rx_tc, rx_attr, rx_len_dw, rx_addr
//                                 incoming header fields
//   rd_valid/rd_ready             MRd32 job to the read engine
//   wr_valid/wr_ready             MWr32 job to the write engine
//   cpl_valid/cpl_ready           completion job to the DMA completion handler
//   out_hdr[77:0]                 {7'b0, req_id, tag, tc, attr, len_dw, addr} of the held header
//   ur_valid/ur_ready/ur_job      UR job FIFO head {req_id, tag, tc, attr}
//   ur_overflow                   sticky: a UR job had to wait for FIFO space
//
//  Optional feature macro PCIE_RX_DISP_STATS_EN adds saturating event counters
//  stat_rd, stat_wr, stat_cpl, stat_ur, stat_drop (CNT_W bits each).
module pcie_rx_req_dispatch #(
   parameter int UR_DEPTH = 4,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_hdr_valid,
   output logic              rx_hdr_ready,
   input  logic [1:0]        rx_fmt,
   input  logic [4:0]        rx_type,
   input  logic [15:0]       rx_req_id,
   input  logic [7:0]        rx_tag,
   input  logic [2:0]        rx_tc,
   input  logic [1:0]        rx_attr,
   input  logic [9:0]        rx_len_dw,
   input  logic [31:0]       rx_addr,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              cpl_valid,
   input  logic              cpl_ready,
   output logic [77:0]       out_hdr,
   output logic              ur_valid,
   input  logic              ur_ready,
   output logic [28:0]       ur_job,
   output logic              ur_overflow
`ifdef PCIE_RX_DISP_STATS_EN
   ,
   output logic [CNT_W-1:0]  stat_rd,
   output logic [CNT_W-1:0]  stat_wr,
   output logic [CNT_W-1:0]  stat_cpl,
   output logic [CNT_W-1:0]  stat_ur,
   output logic [CNT_W-1:0]  stat_drop
`endif
);

   localparam int            PW       = $clog2(UR_DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(UR_DEPTH);
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {S_IDLE, S_DISP, S_URQ} state_t;
   typedef enum logic [2:0] {C_RD, C_WR, C_CPL, C_URNP, C_DROP} cls_t;

   state_t        state_q, state_d;
   logic [1:0]    fmt_q, fmt_d;
   logic [4:0]    type_q, type_d;
   logic [70:0]   hdr_q, hdr_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [28:0]   ur_mem_q [UR_DEPTH];
   cls_t          cls;
   logic          non_posted, full, empty, push, pop;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign pop   = !empty && ur_ready;

   // Classification of the held header. Non-posted requests without a
   // dedicated engine become UR jobs; unknown posted TLPs are dropped.
   always_comb begin
      cls        = C_DROP;
      non_posted = ((type_q == 5'b00000 || type_q == 5'b00001) && !fmt_q[1]) ||
                   ((type_q == 5'b00010 || type_q == 5'b00100 ||
                     type_q == 5'b00101 || type_q == 5'b11011) && !fmt_q[0]);
      if ({fmt_q, type_q} == 7'b00_00000)
         cls = C_RD;
      else if ({fmt_q, type_q} == 7'b10_00000)
         cls = C_WR;
      else if (!fmt_q[0] && type_q[4:1] == 4'b0101)
         cls = C_CPL;
      else if (non_posted)
         cls = C_URNP;
   end

   always_comb begin
      state_d      = state_q;
      fmt_d        = fmt_q;
      type_d       = type_q;
      hdr_d        = hdr_q;
      ovf_d        = ovf_q;
      push         = 1'b0;
      rx_hdr_ready = 1'b0;
      rd_valid     = 1'b0;
      wr_valid     = 1'b0;
      cpl_valid    = 1'b0;
      case (state_q)
         S_IDLE: begin
            rx_hdr_ready = 1'b1;
            if (rx_hdr_valid) begin
               fmt_d   = rx_fmt;
               type_d  = rx_type;
               hdr_d   = {rx_req_id, rx_tag, rx_tc, rx_attr, rx_len_dw, rx_addr};
               state_d = S_DISP;
            end
         end
         S_DISP: begin
            case (cls)
               C_RD: begin
                  rd_valid = 1'b1;
                  if (rd_ready) state_d = S_IDLE;
               end
               C_WR: begin
                  wr_valid = 1'b1;
                  if (wr_ready) state_d = S_IDLE;
               end
               C_CPL: begin
                  cpl_valid = 1'b1;
                  if (cpl_ready) state_d = S_IDLE;
               end
               C_URNP: begin
                  // Full is judged on the registered count, so a same-cycle
                  // pop only frees space for the following cycle.
                  if (!full) begin
                     push    = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     ovf_d   = 1'b1;
                     state_d = S_URQ;
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_URQ: begin
            if (!full) begin
               push    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         hdr_q    <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         hdr_q    <= hdr_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // fmt/type are only consulted in DISP, which always follows a capture.
   always_ff @(posedge clk) begin
      fmt_q  <= fmt_d;
      type_q <= type_d;
      if (push) ur_mem_q[wr_ptr_q] <= hdr_q[70:42];
   end

   assign out_hdr     = {7'b0, hdr_q};
   assign ur_valid    = !empty;
   assign ur_job      = empty ? '0 : ur_mem_q[rd_ptr_q];
   assign ur_overflow = ovf_q;

`ifdef PCIE_RX_DISP_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic [CNT_W-1:0] stat_rd_q, stat_wr_q, stat_cpl_q, stat_ur_q, stat_drop_q;
   logic [CNT_W-1:0] stat_rd_d, stat_wr_d, stat_cpl_d, stat_ur_d, stat_drop_d;

   always_comb begin
      stat_rd_d   = (rd_valid && rd_ready)   ? sat_inc(stat_rd_q)  : stat_rd_q;
      stat_wr_d   = (wr_valid && wr_ready)   ? sat_inc(stat_wr_q)  : stat_wr_q;
      stat_cpl_d  = (cpl_valid && cpl_ready) ? sat_inc(stat_cpl_q) : stat_cpl_q;
      stat_ur_d   = push ? sat_inc(stat_ur_q) : stat_ur_q;
      stat_drop_d = (state_q == S_DISP && cls == C_DROP) ? sat_inc(stat_drop_q) : stat_drop_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_q   <= '0;
         stat_wr_q   <= '0;
         stat_cpl_q  <= '0;
         stat_ur_q   <= '0;
         stat_drop_q <= '0;
      end else begin
         stat_rd_q   <= stat_rd_d;
         stat_wr_q   <= stat_wr_d;
         stat_cpl_q  <= stat_cpl_d;
         stat_ur_q   <= stat_ur_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign stat_rd   = stat_rd_q;
   assign stat_wr   = stat_wr_q;
   assign stat_cpl  = stat_cpl_q;
   assign stat_ur   = stat_ur_q;
   assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_pcie_rx_req_dispatch.sv
module tb_pcie_rx_req_dispatch;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_hdr_valid, rx_hdr_ready;
   logic [1:0]  rx_fmt;
   logic [4:0]  rx_type;
   logic [15:0] rx_req_id;
   logic [7:0]  rx_tag;
   logic [2:0]  rx_tc;
   logic [1:0]  rx_attr;
   logic [9:0]  rx_len_dw;
   logic [31:0] rx_addr;
   logic        rd_valid, rd_ready, wr_valid, wr_ready, cpl_valid, cpl_ready;
   logic [77:0] out_hdr;
   logic        ur_valid, ur_ready, ur_overflow;
   logic [28:0] ur_job;
`ifdef PCIE_RX_DISP_STATS_EN
   logic [CNT_W-1:0] stat_rd, stat_wr, stat_cpl, stat_ur, stat_drop;
`endif

   always #5 clk = ~clk;

   pcie_rx_req_dispatch #(.UR_DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready),
      .rx_fmt(rx_fmt), .rx_type(rx_type), .rx_req_id(rx_req_id), .rx_tag(rx_tag),
      .rx_tc(rx_tc), .rx_attr(rx_attr), .rx_len_dw(rx_len_dw), .rx_addr(rx_addr),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
      .out_hdr(out_hdr),
      .ur_valid(ur_valid), .ur_ready(ur_ready), .ur_job(ur_job),
      .ur_overflow(ur_overflow)
`ifdef PCIE_RX_DISP_STATS_EN
      , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_cpl(stat_cpl),
      .stat_ur(stat_ur), .stat_drop(stat_drop)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind;
      logic [77:0] hdr;
   } exp_t;
   exp_t        exp_q[$];
   logic [28:0] ur_q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 RD, 1 WR, 2 CPL, 3 UR, 4 DROP
   function automatic int classify(input logic [1:0] f, input logic [4:0] t);
      casez ({f, t})
         7'b00_00000: return 0;
         7'b10_00000: return 1;
         7'b?0_0101?: return 2;
         7'b01_00000, 7'b00_00001, 7'b01_00001,
         7'b00_00010, 7'b10_00010, 7'b00_00100, 7'b10_00100,
         7'b00_00101, 7'b10_00101, 7'b00_11011, 7'b10_11011: return 3;
         default: return 4;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] f, input logic [4:0] t, input logic [15:0] rid,
                       input logic [7:0] tg, input logic [2:0] tc, input logic [1:0] at,
                       input logic [9:0] ln, input logic [31:0] ad);
      int          k;
      int          n;
      logic [77:0] h;
      exp_t        e;
      k = classify(f, t);
      h = {7'd0, rid, tg, tc, at, ln, ad};
      rx_fmt = f; rx_type = t; rx_req_id = rid; rx_tag = tg;
      rx_tc = tc; rx_attr = at; rx_len_dw = ln; rx_addr = ad;
      rx_hdr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rx_hdr_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("hdr_accept_within_budget", (n < 50), 1);
      if (k < 3) begin
         e.kind = k;
         e.hdr  = h;
         exp_q.push_back(e);
      end else if (k == 3) begin
         ur_q.push_back({rid, tg, tc, at});
      end
      step();
      rx_hdr_valid = 1'b0;
   endtask

   task automatic mon_disp(input int k);
      exp_t e;
      chk("disp_expected_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("disp_kind", k, e.kind);
         chk("disp_out_hdr", out_hdr, e.hdr);
      end
   endtask

   // Scoreboard monitor: every engine handshake and every UR pop is compared
   // against the queue filled when the header was driven.
   always @(negedge clk) begin
      if (!rst) begin
         chk("valid_onehot0", $onehot0({rd_valid, wr_valid, cpl_valid}), 1);
         if (rd_valid && rd_ready)   mon_disp(0);
         if (wr_valid && wr_ready)   mon_disp(1);
         if (cpl_valid && cpl_ready) mon_disp(2);
         if (ur_valid && ur_ready) begin
            chk("ur_expected_pending", (ur_q.size() != 0), 1);
            if (ur_q.size() != 0) chk("ur_job_order", ur_job, ur_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rx_hdr_valid = 1'b0;
      rx_fmt = '0; rx_type = '0; rx_req_id = '0; rx_tag = '0;
      rx_tc = '0; rx_attr = '0; rx_len_dw = '0; rx_addr = '0;
      rd_ready = 1'b0; wr_ready = 1'b0; cpl_ready = 1'b0; ur_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_hdr_ready", rx_hdr_ready, 1);
      chk("rst_valids", {rd_valid, wr_valid, cpl_valid, ur_valid}, 0);
      chk("rst_out_hdr", out_hdr, 0);
      chk("rst_ur_job", ur_job, 0);
      chk("rst_ur_overflow", ur_overflow, 0);
      step();

      // 1: MRd32 with rd_ready high
      rd_ready = 1'b1;
      send(2'b00, 5'b00000, 16'h1234, 8'h11, 3'd0, 2'd0, 10'd1, 32'h100);
      @(negedge clk);
      chk("t1_rd_valid", rd_valid, 1);
      chk("t1_tag", out_hdr[54:47], 8'h11);
      chk("t1_addr", out_hdr[31:0], 32'h100);
      step();
      @(negedge clk);
      chk("t1_rd_valid_one_cycle", rd_valid, 0);
      chk("t1_idle", rx_hdr_ready, 1);
      step();
      rd_ready = 1'b0;

      // 2: MWr32 with wr_ready low for 5 cycles
      send(2'b10, 5'b00000, 16'h5678, 8'h22, 3'd1, 2'd1, 10'd0, 32'hDEADBEE0);
      for (int i = 0; i < 6; i++) begin
         if (i == 5) wr_ready = 1'b1;
         @(negedge clk);
         chk("t2_wr_valid", wr_valid, 1);
         chk("t2_out_hdr_stable", out_hdr,
             {7'd0, 16'h5678, 8'h22, 3'd1, 2'd1, 10'd0, 32'hDEADBEE0});
         chk("t2_hdr_ready_low", rx_hdr_ready, 0);
         chk("t2_other_valids", {rd_valid, cpl_valid}, 0);
         step();
      end
      wr_ready = 1'b0;
      @(negedge clk);
      chk("t2_wr_valid_dropped", wr_valid, 0);
      chk("t2_idle", rx_hdr_ready, 1);
      step();

      // 3: CfgRd0 becomes a UR job
      send(2'b00, 5'b00100, 16'hABCD, 8'h05, 3'd3, 2'd2, 10'd1, 32'h0);
      @(negedge clk);
      chk("t3_no_engine_valid", {rd_valid, wr_valid, cpl_valid}, 0);
      step();
      @(negedge clk);
      chk("t3_ur_valid", ur_valid, 1);
      chk("t3_ur_job", ur_job, {16'hABCD, 8'h05, 3'd3, 2'd2});
      chk("t3_idle", rx_hdr_ready, 1);
      step();
      ur_ready = 1'b1;
      step();
      ur_ready = 1'b0;
      @(negedge clk);
      chk("t3_fifo_empty", ur_valid, 0);
      step();

      // 4: five UR headers against a 4-deep FIFO
      send(2'b10, 5'b00100, 16'h0001, 8'hA1, 3'd1, 2'd0, 10'd1, 32'h0);
      send(2'b00, 5'b00010, 16'h0002, 8'hA2, 3'd2, 2'd1, 10'd1, 32'h0);
      send(2'b01, 5'b00000, 16'h0003, 8'hA3, 3'd3, 2'd2, 10'd1, 32'h0);
      send(2'b00, 5'b00001, 16'h0004, 8'hA4, 3'd4, 2'd3, 10'd1, 32'h0);
      send(2'b00, 5'b11011, 16'h0005, 8'hA5, 3'd5, 2'd0, 10'd1, 32'h0);
      step();
      @(negedge clk);
      chk("t4_overflow_set", ur_overflow, 1);
      chk("t4_stalled", rx_hdr_ready, 0);
      chk("t4_ur_valid", ur_valid, 1);
      step();
      ur_ready = 1'b1;
      step();
      ur_ready = 1'b0;
      @(negedge clk);
      chk("t4_still_waiting", rx_hdr_ready, 0);
      step();
      @(negedge clk);
      chk("t4_pushed_idle", rx_hdr_ready, 1);
      step();
      ur_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_drain_count", ur_valid, 1);
         step();
      end
      ur_ready = 1'b0;
      @(negedge clk);
      chk("t4_drained_empty", ur_valid, 0);
      chk("t4_overflow_sticky", ur_overflow, 1);
      step();

      // 5: dropped posted TLPs, then a CplD
      send(2'b11, 5'b10000, 16'h0BAD, 8'h31, 3'd0, 2'd0, 10'd2, 32'h40);
      @(negedge clk);
      chk("t5_msgd_no_valid", {rd_valid, wr_valid, cpl_valid}, 0);
      step();
      send(2'b11, 5'b00000, 16'h0BAD, 8'h32, 3'd0, 2'd0, 10'd2, 32'h80);
      @(negedge clk);
      chk("t5_mwr4_no_valid", {rd_valid, wr_valid, cpl_valid}, 0);
      step();
      @(negedge clk);
      chk("t5_fifo_unchanged", ur_valid, 0);
      chk("t5_idle", rx_hdr_ready, 1);
      step();
      cpl_ready = 1'b1;
      send(2'b10, 5'b01010, 16'h7777, 8'h44, 3'd2, 2'd3, 10'd4, 32'h0);
      @(negedge clk);
      chk("t5_cpl_valid", cpl_valid, 1);
      step();
      cpl_ready = 1'b0;
      @(negedge clk);
      chk("t5_cpl_done", cpl_valid, 0);
`ifdef PCIE_RX_DISP_STATS_EN
      chk("stat_rd", stat_rd, 1);
      chk("stat_wr", stat_wr, 1);
      chk("stat_cpl", stat_cpl, 1);
      chk("stat_ur", stat_ur, 6);
      chk("stat_drop", stat_drop, 2);
`endif
      chk("scoreboard_drained", exp_q.size() + ur_q.size(), 0);
      step();

      // 6: reset in DISP with two UR jobs queued
      send(2'b00, 5'b00101, 16'h00C1, 8'h51, 3'd0, 2'd0, 10'd1, 32'h0);
      send(2'b10, 5'b00101, 16'h00C2, 8'h52, 3'd0, 2'd0, 10'd1, 32'h0);
      send(2'b00, 5'b00000, 16'h00C3, 8'h53, 3'd0, 2'd0, 10'd1, 32'h200);
      @(negedge clk);
      chk("t6_rd_valid_before_rst", rd_valid, 1);
      chk("t6_ur_valid_before_rst", ur_valid, 1);
      step();
      rst = 1'b1;
      exp_q.delete();
      ur_q.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rd_valid_cleared", rd_valid, 0);
      chk("t6_ur_valid_cleared", ur_valid, 0);
      chk("t6_hdr_ready", rx_hdr_ready, 1);
      chk("t6_overflow_cleared", ur_overflow, 0);
      chk("t6_out_hdr_cleared", out_hdr, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
